ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single-port DPI-backed word RAM between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Runs one outstanding access at a time. Each access uses a valid/ready request channel and a valid/ready response channel per requester.
- Drives the RAM's addr/mem_wen/valid/wdata pins and captures its rdata.
- Sits between the core frontends and the RAM in the top level, replacing direct per-unit RAM instances.

Parameters:
- ADDR_WIDTH, 32, byte-address width of all addr ports.
- DATA_WIDTH, 32, word width of all data ports.
- MEM_LAT, 1, cycles mem_valid is held per access; rdata is sampled at the posedge ending the last held cycle; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_WIDTH  IFU byte address.
- ifu_resp_valid  out  1  IFU read data valid.
- ifu_resp_ready  in  1  IFU consumes response.
- ifu_resp_rdata  out  DATA_WIDTH  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_addr  in  ADDR_WIDTH  LSU byte address.
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_wdata  in  DATA_WIDTH  LSU write data.
- lsu_resp_valid  out  1  LSU access complete.
- lsu_resp_ready  in  1  LSU consumes response.
- lsu_resp_rdata  out  DATA_WIDTH  word read at the address before any write.
- mem_valid  out  1  to RAM valid.
- mem_addr  out  ADDR_WIDTH  to RAM addr, word aligned.
- mem_wen  out  1  to RAM mem_wen.
- mem_wdata  out  DATA_WIDTH  to RAM wdata.
- mem_rdata  in  DATA_WIDTH  from RAM rdata.

Behaviour:
- Reset values:
  - state IDLE, cnt 0, last_grant = LSU, so the IFU wins the first tie.
  - All *_ready, *_resp_valid, mem_valid and mem_wen are 0.
  - mem_addr, mem_wdata and the rdata buffers are 0.
- FSM states:
  - IDLE:
    - Arbitrate among requesters with req_valid high.
    - If only one requests, it wins. If both request, the one not equal to last_grant wins (round robin).
    - Winner's req_ready = 1 combinationally in IDLE only; the loser's req_ready = 0.
    - On the handshake edge, latch addr with [1:0] forced to 0, latch wen and wdata, set last_grant = winner and go to ACCESS.
    - IFU wen is always 0.
  - ACCESS:
    - mem_valid = 1; mem_addr/mem_wen/mem_wdata come from the latches and are stable for the whole state.
    - cnt counts 0..MEM_LAT-1.
    - At the posedge ending cnt = MEM_LAT-1, capture mem_rdata into the winner's rdata buffer and go to RESP.
  - RESP:
    - Winner's resp_valid = 1 and resp_rdata is held.
    - mem_valid = 0 and mem_wen = 0.
    - On resp_valid & resp_ready, go to IDLE. The next arbitration happens in that IDLE cycle, not the same edge.
- Latency:
  - Handshake at edge N; mem_valid high for cycles N+1..N+MEM_LAT.
  - resp_valid rises in cycle N+MEM_LAT+1.
  - With ready always high, back-to-back accesses take MEM_LAT+2 cycles each.
- Outside ACCESS, mem_valid = 0 and mem_wen = 0. A write therefore reaches the RAM exactly once per access and no spurious access occurs.
- Non-winner resp_valid is always 0. Both resp_valid are never high together.
- Backpressure: resp_ready held low keeps the FSM in RESP indefinitely; no new request is accepted.
- A req_valid dropped before the handshake is legal and ignored. Request fields are not sampled after the handshake.
- Reset asserted mid-ACCESS or mid-RESP:
  - Immediate return to IDLE; mem_valid falls asynchronously.
  - The in-flight response is discarded; no resp_valid is issued after reset.
- Misaligned addr is silently aligned; no error is reported.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - requester ID constants REQ_IFU = 0, REQ_LSU = 1.
  - MEM_LAT counter width constant (4 bits).
- Sub-module rr_arb2: 2-input round-robin grant from (req[1:0], last_grant); purely combinational, instanced once.

Test Plan:
- Single IFU read, addr 0x8000_0006, RAM word 0x1234_5678, MEM_LAT=1 -> mem_addr 0x8000_0004, mem_valid high exactly 1 cycle, ifu_resp_rdata 0x1234_5678 two cycles after handshake.
- Simultaneous IFU read 0x100 and LSU write 0x200 data 0xDEAD_BEEF from reset -> IFU served first, then LSU. mem_wen pulses only during the LSU ACCESS. A following LSU read of 0x200 returns 0xDEAD_BEEF.
- Both requesters held valid for 6 accesses -> grants alternate IFU, LSU, IFU, ...; neither requester starves.
- MEM_LAT=3, lsu_resp_ready low for 5 cycles -> mem_valid high 3 cycles, FSM stays in RESP, ifu_req_ready stays 0 throughout, lsu_resp_rdata stable.
- Reset pulsed during ACCESS of an LSU write -> mem_valid drops immediately, no resp_valid afterwards; first post-reset IFU request is granted normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - two-way round-robin grant, combinational
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_IFU;
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req[REQ_LSU]) begin
      grant_id = REQ_LSU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-outstanding arbiter sharing one word RAM between IFU and LSU
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_resp_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic                  lsu_req_wen,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t                state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic                  last_grant;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, ifu_rdata_q, lsu_rdata_q;
  logic                  grant_valid, grant_id, resp_fire;

  rr_arb2 u_arb (
    .req         ({lsu_req_valid, ifu_req_valid}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign resp_fire = (last_grant == REQ_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (grant_valid)      next_state = ACCESS;
      ACCESS:  if (cnt == LAST_CNT)  next_state = RESP;
      RESP:    if (resp_fire)        next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  // last_grant doubles as the owner of the access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      last_grant  <= REQ_LSU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        last_grant <= grant_id;
        addr_q     <= ((grant_id == REQ_LSU) ? lsu_req_addr : ifu_req_addr) & WORD_MASK;
        wen_q      <= (grant_id == REQ_LSU) && lsu_req_wen;
        wdata_q    <= (grant_id == REQ_LSU) ? lsu_req_wdata : '0;
      end
      if (state == ACCESS) begin
        if (cnt == LAST_CNT) begin
          cnt <= '0;
          if (last_grant == REQ_LSU) lsu_rdata_q <= mem_rdata;
          else                       ifu_rdata_q <= mem_rdata;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_valid      = 1'b0;
    mem_wen        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset && grant_valid) begin
          ifu_req_ready = (grant_id == REQ_IFU);
          lsu_req_ready = (grant_id == REQ_LSU);
        end
      end
      ACCESS: begin
        mem_valid = 1'b1;
        mem_wen   = wen_q;
      end
      RESP: begin
        ifu_resp_valid = (last_grant == REQ_IFU);
        lsu_resp_valid = (last_grant == REQ_LSU);
      end
      default: ;
    endcase
  end

  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign ifu_resp_rdata = ifu_rdata_q;
  assign lsu_resp_rdata = lsu_rdata_q;

endmodule
